// File: rtl/neuron_timestep_scheduler.sv
// neuron_timestep_scheduler: serves every neuron through one shared potential adder per timestep,
// holding per-neuron model/threshold/potential and committing adder results plus spikes.
module neuron_timestep_scheduler #(
  parameter int          N_NEURONS = 10,
  parameter int          IDX_W     = 4,
  parameter int          ADDER_LAT = 2,
  parameter logic [31:0] DEF_VTH   = 32'h42910000,
  parameter logic [31:0] V_RESET   = 32'h00000000
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [1:0]           cfg_model,
  input  logic [31:0]          cfg_vth,
  input  logic                 clear_pot,
  output logic [IDX_W-1:0]     weight_idx,
  input  logic [31:0]          weight_in,
  output logic                 adder_valid,
  output logic [31:0]          adder_weight,
  output logic [31:0]          adder_potential,
  output logic [1:0]           adder_model,
  output logic [31:0]          adder_vth,
  input  logic [31:0]          adder_result,
  input  logic                 adder_spike,
  output logic [N_NEURONS-1:0] spike_vec
);
  localparam int CNT_W = $clog2(ADDER_LAT + 1);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_DONE} state_t;
  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy, r_done, r_valid;
  logic [31:0]          r_weight, r_apot, r_avth;
  logic [1:0]           r_amodel;
  logic [N_NEURONS-1:0] r_spike;
  logic [31:0]          r_pot   [N_NEURONS];
  logic [1:0]           r_model [N_NEURONS];
  logic [31:0]          r_vth   [N_NEURONS];
  logic                 w_last, w_cfg_ok;
  assign w_last   = r_idx == IDX_W'(N_NEURONS - 1);
  assign w_cfg_ok = cfg_we && (32'(cfg_addr) < N_NEURONS);
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_weight <= '0;
      r_apot   <= '0;
      r_avth   <= '0;
      r_amodel <= '0;
      r_spike  <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_pot[i]   <= V_RESET;
        r_model[i] <= 2'b00;
        r_vth[i]   <= DEF_VTH;
      end
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (w_cfg_ok) begin
            r_model[cfg_addr] <= cfg_model;
            r_vth[cfg_addr]   <= cfg_vth;
          end
          if (clear_pot)
            for (int i = 0; i < N_NEURONS; i++) r_pot[i] <= V_RESET;
          if (start) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
            r_spike <= '0;
          end
        end
        S_ISSUE: begin
          r_weight <= weight_in;
          r_apot   <= r_pot[r_idx];
          r_amodel <= r_model[r_idx];
          r_avth   <= r_vth[r_idx];
          r_valid  <= 1'b1;
          r_cnt    <= CNT_W'(ADDER_LAT - 1);
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_COMMIT;
          else r_cnt <= r_cnt - 1'b1;
        end
        S_COMMIT: begin
          r_pot[r_idx]   <= adder_result;
          r_spike[r_idx] <= adder_spike;
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy            = r_busy;
  assign done            = r_done;
  assign weight_idx      = r_idx;
  assign adder_valid     = r_valid;
  assign adder_weight    = r_weight;
  assign adder_potential = r_apot;
  assign adder_model     = r_amodel;
  assign adder_vth       = r_avth;
  assign spike_vec       = r_spike;
endmodule

// File: tb/tb_neuron_timestep_scheduler.sv
// tb_neuron_timestep_scheduler: directed timesteps against a stub adder (result = potential + 1).
module tb_neuron_timestep_scheduler;
  localparam logic [31:0] DEF_VTH = 32'h42910000;
  logic        CLK = 1'b0, reset = 1'b1, start = 1'b0, cfg_we = 1'b0, clear_pot = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [1:0]  cfg_model = '0;
  logic [31:0] cfg_vth = '0;
  logic        busy, done, adder_valid, adder_spike;
  logic [3:0]  weight_idx;
  logic [31:0] weight_in, adder_weight, adder_potential, adder_vth, adder_result;
  logic [1:0]  adder_model;
  logic [9:0]  spike_vec, spike_mask = '0;
  logic [31:0] exp_pot [10];
  logic [1:0]  exp_model [10];
  logic [31:0] exp_vth [10];
  int          n_chk = 0, n_fail = 0;

  neuron_timestep_scheduler dut (
    .CLK(CLK), .reset(reset), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_model(cfg_model), .cfg_vth(cfg_vth),
    .clear_pot(clear_pot), .weight_idx(weight_idx), .weight_in(weight_in),
    .adder_valid(adder_valid), .adder_weight(adder_weight), .adder_potential(adder_potential),
    .adder_model(adder_model), .adder_vth(adder_vth), .adder_result(adder_result),
    .adder_spike(adder_spike), .spike_vec(spike_vec)
  );

  always #5 CLK = ~CLK;
  assign weight_in    = 32'h100 + 32'(weight_idx);
  assign adder_result = adder_potential + 32'd1;
  assign adder_spike  = spike_mask[weight_idx];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 10; i++) begin
      exp_pot[i]   = 32'h0;
      exp_model[i] = 2'b00;
      exp_vth[i]   = DEF_VTH;
    end
  endtask

  task automatic run_ts(input logic [9:0] mask, input int xs_cyc, input int bc_cyc, input int abort_cyc);
    int nv = 0, nd = 0, dc = 0;
    spike_mask = mask;
    start = 1'b1;
    tick;
    start = 1'b0; cfg_we = 1'b0; clear_pot = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 1) chk("busy_first", 32'(busy), 32'd1);
      if (adder_valid) begin
        chk("valid_idx", 32'(weight_idx), 32'(nv));
        if (nv < 10) begin
          chk("adder_weight", adder_weight, 32'h100 + 32'(nv));
          chk("adder_potential", adder_potential, exp_pot[nv]);
          chk("adder_model", 32'(adder_model), 32'(exp_model[nv]));
          chk("adder_vth", adder_vth, exp_vth[nv]);
          exp_pot[nv] = exp_pot[nv] + 32'd1;
        end
        nv++;
      end
      if (done) begin
        nd++;
        dc = c;
        chk("busy_at_done", 32'(busy), 32'd1);
      end
      if (c == 42) chk("busy_after_done", 32'(busy), 32'd0);
      if (c == abort_cyc) begin
        chk("spike_before_abort", 32'(spike_vec), 32'(mask & 10'h007));
        reset = 1'b1;
        tick;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(adder_valid), 32'd0);
        chk("abort_spike", 32'(spike_vec), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        model_reset;
        return;
      end
      start = (c == xs_cyc);
      if (c == bc_cyc) begin
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_model = 2'b10; cfg_vth = 32'hDEADBEEF;
      end else cfg_we = 1'b0;
      tick;
    end
    start = 1'b0;
    cfg_we = 1'b0;
    chk("valid_count", 32'(nv), 32'd10);
    chk("done_count", 32'(nd), 32'd1);
    chk("done_cycle", 32'(dc), 32'd41);
    chk("spike_vec", 32'(spike_vec), 32'(mask));
  endtask

  initial begin
    tick;
    tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_spike", 32'(spike_vec), 32'd0);
    chk("rst_valid", 32'(adder_valid), 32'd0);
    chk("rst_idx", 32'(weight_idx), 32'd0);
    chk("rst_vth_reg", adder_vth, 32'd0);
    chk("rst_pot_reg", adder_potential, 32'd0);
    reset = 1'b0;
    model_reset;
    tick;
    run_ts(10'h088, 5, 0, 0);
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_model = 2'b01; cfg_vth = 32'h42200000;
    tick;
    cfg_addr = 4'd12; cfg_model = 2'b11; cfg_vth = 32'hFFFFFFFF;
    tick;
    cfg_we = 1'b0;
    exp_model[2] = 2'b01;
    exp_vth[2]   = 32'h42200000;
    run_ts(10'h201, 0, 10, 0);
    tick;
    clear_pot = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_model = 2'b10; cfg_vth = 32'h3F800000;
    for (int i = 0; i < 10; i++) exp_pot[i] = 32'h0;
    exp_model[5] = 2'b10;
    exp_vth[5]   = 32'h3F800000;
    run_ts(10'h000, 0, 0, 0);
    tick;
    run_ts(10'h001, 0, 0, 15);
    tick;
    run_ts(10'h3FF, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
